// File: rtl/kanagawa_ram_arb_pkg.sv
// kanagawa_ram_arb_pkg: shared FSM state type and requester-id width helper for the RAM port arbiter
package kanagawa_ram_arb_pkg;
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } arb_state_e;
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/kanagawa_rr_arbiter.sv
// kanagawa_rr_arbiter: round-robin grant among NUM_REQ requesters
// clk, rst  : clock, synchronous active-high reset (pointer returns to 0)
// en        : grants permitted this cycle
// valid     : per-requester request
// grant     : one-hot grant or zero, combinational in valid and pointer
// grant_id  : index of the granted requester (0 when none)
// grant_any : a grant is issued this cycle
module kanagawa_rr_arbiter
    import kanagawa_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);
    logic [ID_W-1:0] ptr;
    function automatic logic [ID_W-1:0] wrap(input int s);
        return ID_W'((s >= NUM_REQ) ? s - NUM_REQ : s);
    endfunction
    always_comb begin
        grant_any = 1'b0;
        grant_id = '0;
        // descending scan: the candidate nearest the pointer is written last and wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (en && valid[wrap(int'(ptr) + k)]) begin
                grant_any = 1'b1;
                grant_id = wrap(int'(ptr) + k);
            end
        end
        grant = NUM_REQ'(grant_any) << grant_id;
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (grant_any)
            ptr <= wrap(int'(grant_id) + 1);
    end
endmodule

// File: rtl/kanagawa_ram_port_arbiter.sv
// kanagawa_ram_port_arbiter: round-robin sharing of one simple dual-port RAM among NUM_REQ requesters
// clk, rst          : sole clock, synchronous active-high reset
// rd_req_*          : per-requester read valid/address in, one-hot read grant out
// wr_req_*          : per-requester write valid/address/data in, one-hot write grant out
// rd_rsp_*          : read response, READ_LATENCY cycles after the grant, no backpressure
// ram_*             : RAM read address, read data, write enable/address/data
// init_done         : high once the optional zero-fill has finished and requests are accepted
// Build option: define KANAGAWA_RAM_ARB_FORWARD_EN to return same-cycle write data to a
// colliding read instead of the old RAM contents.
module kanagawa_ram_port_arbiter
    import kanagawa_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int READ_LATENCY = 2,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            rd_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr,
    output logic [NUM_REQ-1:0]            rd_req_ready,
    input  logic [NUM_REQ-1:0]            wr_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_req_data,
    output logic [NUM_REQ-1:0]            wr_req_ready,
    output logic                          rd_rsp_valid,
    output logic [ID_W-1:0]               rd_rsp_id,
    output logic [DATA_WIDTH-1:0]         rd_rsp_data,
    output logic [ADDR_WIDTH-1:0]         ram_readaddr_out,
    input  logic [DATA_WIDTH-1:0]         ram_data_in,
    output logic                          ram_wren_out,
    output logic [ADDR_WIDTH-1:0]         ram_writeaddr_out,
    output logic [DATA_WIDTH-1:0]         ram_data_out,
    output logic                          init_done
);
    localparam arb_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    arb_state_e state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic run;
    logic rd_any, wr_any;
    logic [ID_W-1:0] rd_id, wr_id;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [DATA_WIDTH-1:0] wr_data, rsp_data;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [ID_W-1:0] pipe_id [READ_LATENCY];
    // gating with rst keeps every grant (and hence every output) low during reset
    assign run = (state == ST_RUN) && !rst;
    assign init_done = run;
    kanagawa_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk(clk),
        .rst(rst),
        .en(run),
        .valid(rd_req_valid),
        .grant(rd_req_ready),
        .grant_id(rd_id),
        .grant_any(rd_any)
    );
    kanagawa_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk(clk),
        .rst(rst),
        .en(run),
        .valid(wr_req_valid),
        .grant(wr_req_ready),
        .grant_id(wr_id),
        .grant_any(wr_any)
    );
    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_req_ready[i])
                rd_addr = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (wr_req_ready[i]) begin
                wr_addr = wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data = wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    assign ram_readaddr_out = rd_addr;
    always_ff @(posedge clk) begin
        if (rst)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        ram_wren_out = 1'b0;
        ram_writeaddr_out = '0;
        ram_data_out = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                ram_wren_out = 1'b1;
                ram_writeaddr_out = init_addr;
                state_nxt = (init_addr == '1) ? ST_RUN : ST_INIT;
            end else if (wr_any) begin
                ram_wren_out = 1'b1;
                ram_writeaddr_out = wr_addr;
                ram_data_out = wr_data;
            end
        end
    end
    // wraps to 0 on the last address, leaving it cleared for the next INIT pass
    always_ff @(posedge clk) begin
        if (rst || state != ST_INIT)
            init_addr <= '0;
        else
            init_addr <= init_addr + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst)
            pipe_v <= '0;
        else
            pipe_v <= READ_LATENCY'({pipe_v, rd_any});
    end
    always_ff @(posedge clk) begin
        pipe_id[0] <= rd_id;
        for (int i = 1; i < READ_LATENCY; i++)
            pipe_id[i] <= pipe_id[i-1];
    end
`ifdef KANAGAWA_RAM_ARB_FORWARD_EN
    logic [READ_LATENCY-1:0] pipe_f;
    logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];
    // a colliding write's data rides alongside the read and replaces the stale RAM word
    always_ff @(posedge clk) begin
        pipe_f <= READ_LATENCY'({pipe_f, rd_any && wr_any && rd_addr == wr_addr});
        pipe_d[0] <= wr_data;
        for (int i = 1; i < READ_LATENCY; i++)
            pipe_d[i] <= pipe_d[i-1];
    end
    assign rsp_data = pipe_f[READ_LATENCY-1] ? pipe_d[READ_LATENCY-1] : ram_data_in;
`else
    assign rsp_data = ram_data_in;
`endif
    assign rd_rsp_valid = pipe_v[READ_LATENCY-1] && !rst;
    assign rd_rsp_id = rd_rsp_valid ? pipe_id[READ_LATENCY-1] : '0;
    assign rd_rsp_data = rd_rsp_valid ? rsp_data : '0;
endmodule

// File: doc/kanagawa_ram_port_arbiter.md
KANAGAWA_RAM_PORT_ARBITER -- requirements
Module: kanagawa_ram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, RAM address width.
REQ-004 SHALL have parameter READ_LATENCY, default 2, RAM read latency in cycles (1..4).
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the RAM after reset.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk  input  1  sole clock; rst  input  1  synchronous active-high reset.
REQ-007 SHALL have these ports; ID_W = max(1, clog2(NUM_REQ)):
- rd_req_valid  input  NUM_REQ  per-requester read request
- rd_req_addr  input  NUM_REQ*ADDR_WIDTH  read addresses, requester i at slice i
- rd_req_ready  output  NUM_REQ  read grant, one-hot or zero
- wr_req_valid  input  NUM_REQ  per-requester write request
- wr_req_addr  input  NUM_REQ*ADDR_WIDTH  write addresses
- wr_req_data  input  NUM_REQ*DATA_WIDTH  write data
- wr_req_ready  output  NUM_REQ  write grant, one-hot or zero
- rd_rsp_valid  output  1  read data valid
- rd_rsp_id  output  ID_W  requester index of the response
- rd_rsp_data  output  DATA_WIDTH  read data
- ram_readaddr_out  output  ADDR_WIDTH  to RAM readaddr_in
- ram_data_in  input  DATA_WIDTH  from RAM data_out
- ram_wren_out  output  1  to RAM wren_in
- ram_writeaddr_out  output  ADDR_WIDTH  to RAM writeaddr_in
- ram_data_out  output  DATA_WIDTH  to RAM data_in
- init_done  output  1  high once requests are accepted

Function
REQ-008 SHALL implement FSM with states INIT and RUN; after reset INIT if CLEAR_ON_RESET=1, else RUN.
REQ-009 In INIT SHALL write zero to address 0, 1, ... 2^ADDR_WIDTH-1, one per cycle, then enter RUN on the cycle after the last address is written; all ready outputs low, init_done low.
REQ-010 In RUN, init_done SHALL be high.
REQ-011 Read and write ports SHALL be arbitrated independently, each round-robin with its own pointer.
REQ-012 Grant SHALL go to the lowest index i, searched cyclically from the pointer, with valid[i] high; ready is a combinational function of valid and the pointer.
REQ-013 After a grant to i, that pointer SHALL become (i+1) mod NUM_REQ; with no grant it is unchanged.
REQ-014 A granted read SHALL drive ram_readaddr_out with that requester's address in the same cycle.
REQ-015 A granted write SHALL assert ram_wren_out with that requester's address and data in the same cycle.
REQ-016 ram_wren_out SHALL be low when no write is granted and not in INIT.
REQ-017 rd_rsp_valid SHALL pulse exactly READ_LATENCY cycles after the grant cycle, with rd_rsp_id equal to the granted index and rd_rsp_data equal to ram_data_in.
REQ-018 Responses SHALL have no backpressure; up to READ_LATENCY reads may be in flight, one issued per cycle back-to-back.
REQ-019 When rd_rsp_valid is low, rd_rsp_id and rd_rsp_data SHALL be 0.
REQ-020 Without forwarding, a read and write to the same address granted in the same cycle SHALL return the old RAM contents.

Reset
REQ-021 On rst, the following SHALL be cleared: both pointers to 0; the response pipeline (no rd_rsp_valid for in-flight reads, including reset mid-flight); the INIT address counter to 0.
REQ-022 While rst is high, all outputs SHALL be 0.

Configuration
REQ-023 With KANAGAWA_RAM_ARB_FORWARD_EN defined, a read and write granted in the same cycle to the same address SHALL return the write data in place of ram_data_in at the normal latency; without the macro, REQ-020 applies and no forwarding logic exists.

Structure
REQ-024 A package kanagawa_ram_arb_pkg SHALL hold the FSM state enum and the ID_W computation function.
REQ-025 Round-robin logic SHALL be one sub-module, kanagawa_rr_arbiter, instantiated twice (read, write).

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> 16 zero writes to addresses 0..15, init_done rises on the 17th cycle after rst drops.
- NUM_REQ=3, all read valids held high -> grants cycle 0,1,2,0; responses 2 cycles later with ids 0,1,2,0.
- Requester 1 writes 0xDEADBEEF to address 5, requester 0 reads address 5 next cycle -> rd_rsp_data=0xDEADBEEF, id 0, 2 cycles after the read grant.
- Same-cycle write 0x1234 and read of address 7 holding 0x0 -> response 0x1234 with macro defined, 0x0 without.
- rst asserted one cycle after a read grant -> rd_rsp_valid never asserts; pointers restart at 0.
- Only requester 2 valid, pointer at 0 -> requester 2 granted immediately; pointer becomes 0.
